// File: rtl/fir_mac_sequencer_pkg.sv
// fir_mac_sequencer_pkg: FSM state encoding and default sizes
// shared by the FIR MAC sequencer, its interface and its bench.
package fir_mac_sequencer_pkg;

  localparam int DW_DEF   = 32;
  localparam int TAPS_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_X,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: ap control, x/y sample streams and tap-RAM
// read port. slave = sequencer side, master = wrapper/storage side.
interface fir_mac_sequencer_if
  import fir_mac_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int TAP_NUM    = TAPS_DEF,
  parameter int AW         = $clog2(TAP_NUM)
);
  logic                  ap_start;
  logic [31:0]           data_length;
  logic                  ap_idle;
  logic                  ap_done;
  logic                  x_valid;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  x_ready;
  logic [AW-1:0]         tap_addr;
  logic [DATA_WIDTH-1:0] tap_rdata;
  logic                  y_valid;
  logic [DATA_WIDTH-1:0] y_data;
  logic                  y_ready;

  modport slave (
    input  ap_start, data_length,
    input  x_valid, x_data,
    input  tap_rdata, y_ready,
    output ap_idle, ap_done, x_ready,
    output tap_addr, y_valid, y_data
  );

  modport master (
    output ap_start, data_length,
    output x_valid, x_data,
    output tap_rdata, y_ready,
    input  ap_idle, ap_done, x_ready,
    input  tap_addr, y_valid, y_data
  );
endinterface

// File: rtl/fir_mac_sequencer_mac_unit.sv
// fir_mac_sequencer_mac_unit: clear/enable multiply-accumulate.
// Ports: clr_i zeroes acc, en_i adds a_i*b_i (wrapping), acc_o.
module fir_mac_sequencer_mac_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] acc_o
);
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_d;
  logic [DATA_WIDTH-1:0] prod;

  // Low half of a two's complement product is the same
  // whether operands are read signed or unsigned.
  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + prod;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: runs TAP_NUM MACs per sample over a circular
// buffer. Ports: wb_clk_i, wb_rst_i (sync, high), bus (slave).
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int TAP_NUM    = TAPS_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  fir_mac_sequencer_if.slave bus
);
  localparam int AW = $clog2(TAP_NUM);
  localparam logic [AW:0]   K_LAST = (AW+1)'(TAP_NUM);
  localparam logic [AW:0]   K_PEN  = (AW+1)'(TAP_NUM - 1);
  localparam logic [AW:0]   K_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] A_ONE  = AW'(1);

  state_t                state_q;
  logic                  ap_idle_q;
  logic                  ap_done_q;
  logic                  x_ready_q;
  logic                  y_valid_q;
  logic [AW-1:0]         tap_addr_q;
  logic [AW-1:0]         wptr_q;
  logic [AW:0]           k_q;
  logic [31:0]           cnt_q;
  logic [31:0]           len_q;
  logic [DATA_WIDTH-1:0] smp_q [TAP_NUM];

  logic                  x_fire;
  logic                  mac_en;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] acc;

  assign x_fire = (state_q == S_WAIT_X) && bus.x_valid;
  assign mac_en = (state_q == S_MAC) && (k_q != '0);
  // MAC cycle k pairs tap k-1 with x[n-(k-1)].
  assign rd_idx = wptr_q - k_q[AW-1:0] + A_ONE;

  fir_mac_sequencer_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mac (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .clr_i (x_fire),
    .en_i  (mac_en),
    .a_i   (bus.tap_rdata),
    .b_i   (smp_q[rd_idx]),
    .acc_o (acc)
  );

  always_ff @(posedge wb_clk_i) begin
    if (state_q == S_CLEAR)
      smp_q[k_q[AW-1:0]] <= '0;
    else if (x_fire)
      smp_q[wptr_q] <= bus.x_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      ap_idle_q  <= 1'b1;
      ap_done_q  <= 1'b0;
      x_ready_q  <= 1'b0;
      y_valid_q  <= 1'b0;
      tap_addr_q <= '0;
      wptr_q     <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
    end else begin
      ap_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.ap_start) begin
            len_q     <= bus.data_length;
            cnt_q     <= '0;
            k_q       <= '0;
            ap_idle_q <= 1'b0;
            if (bus.data_length == '0) begin
              state_q   <= S_DONE;
              ap_done_q <= 1'b1;
            end else begin
              state_q <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          wptr_q <= '0;
          if (k_q == K_PEN) begin
            k_q       <= '0;
            x_ready_q <= 1'b1;
            state_q   <= S_WAIT_X;
          end else begin
            k_q <= k_q + K_ONE;
          end
        end
        S_WAIT_X: begin
          if (bus.x_valid) begin
            k_q       <= '0;
            x_ready_q <= 1'b0;
            state_q   <= S_MAC;
          end
        end
        S_MAC: begin
          tap_addr_q <= (k_q < K_PEN) ? tap_addr_q + A_ONE : '0;
          if (k_q == K_LAST) begin
            k_q       <= '0;
            y_valid_q <= 1'b1;
            state_q   <= S_OUT;
          end else begin
            k_q <= k_q + K_ONE;
          end
        end
        S_OUT: begin
          if (bus.y_ready) begin
            y_valid_q <= 1'b0;
            cnt_q     <= cnt_q + 32'd1;
            wptr_q    <= wptr_q + A_ONE;
            if (cnt_q + 32'd1 == len_q) begin
              ap_done_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              x_ready_q <= 1'b1;
              state_q   <= S_WAIT_X;
            end
          end
        end
        S_DONE: begin
          ap_idle_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ap_idle  = ap_idle_q;
  assign bus.ap_done  = ap_done_q;
  assign bus.x_ready  = x_ready_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.y_data   = acc;
  assign bus.tap_addr = tap_addr_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed scenarios for the FIR MAC sequencer
// with a 1-cycle-latency tap RAM model.
module tb_fir_mac_sequencer;
  localparam int TN = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   done_cnt;
  int   xr_cnt;
  int   yv_cnt;
  int   lat;
  bit   tmo;

  logic [31:0] taps [TN];
  logic [31:0] xv   [TN];
  logic [31:0] yv   [TN];

  fir_mac_sequencer_if #(.DATA_WIDTH(32), .TAP_NUM(TN)) bus ();

  fir_mac_sequencer #(
    .DATA_WIDTH (32),
    .TAP_NUM    (TN)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.tap_rdata <= taps[bus.tap_addr];

  initial begin
    done_cnt = 0;
    xr_cnt   = 0;
    yv_cnt   = 0;
  end
  always @(posedge clk) begin
    if (bus.ap_done === 1'b1) done_cnt++;
    if (bus.x_ready === 1'b1) xr_cnt++;
    if (bus.y_valid === 1'b1) yv_cnt++;
  end

  task automatic set_taps(input logic [31:0] h0,
                          input logic [31:0] h1);
    for (int i = 0; i < TN; i++) taps[i] = 32'd0;
    taps[0] = h0;
    taps[1] = h1;
  endtask

  task automatic do_run(input int len);
    int g;
    tmo = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.ap_start    = 1'b1;
    bus.data_length = len;
    @(negedge clk);
    bus.ap_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      g = 0;
      while (bus.x_ready !== 1'b1 && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) tmo = 1'b1;
      bus.x_valid = 1'b1;
      bus.x_data  = xv[i];
      @(negedge clk);
      bus.x_valid = 1'b0;
      g = 1;
      while (bus.y_valid !== 1'b1 && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) tmo = 1'b1;
      if (i == 0) lat = g;
      yv[i] = bus.y_data;
      bus.y_ready = 1'b1;
      @(negedge clk);
      bus.y_ready = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    n_cmp++;
    if (bus.ap_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ap_idle got %b want 1", bus.ap_idle);
    end
    n_cmp++;
    if (bus.ap_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ap_done got %b want 0", bus.ap_done);
    end
    n_cmp++;
    if (bus.x_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_x_ready got %b want 0", bus.x_ready);
    end
    n_cmp++;
    if (bus.y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_y_valid got %b want 0", bus.y_valid);
    end
    n_cmp++;
    if (bus.y_data !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_y_data got %h want 0", bus.y_data);
    end
    n_cmp++;
    if (bus.tap_addr !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_tap_addr got %0d want 0", bus.tap_addr);
    end
  endtask

  task automatic test_identity;
    logic [31:0] exp [3];
    int d0;
    exp[0] = 32'd5;
    exp[1] = 32'd7;
    exp[2] = 32'hFFFF_FFFE;
    set_taps(32'd1, 32'd0);
    xv[0] = 32'd5;
    xv[1] = 32'd7;
    xv[2] = 32'hFFFF_FFFE;
    d0 = done_cnt;
    do_run(3);
    n_cmp++;
    if (tmo !== 1'b0) begin
      n_bad++;
      $display("FAIL ident_timeout got %b want 0", tmo);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (yv[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL ident_y%0d got %h want %h", i, yv[i], exp[i]);
      end
    end
    n_cmp++;
    if (lat !== TN + 2) begin
      n_bad++;
      $display("FAIL ident_latency got %0d want %0d", lat, TN + 2);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL ident_done_pulses got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_signed;
    logic [31:0] exp [3];
    exp[0] = 32'd6;
    exp[1] = 32'd7;
    exp[2] = 32'hFFFF_FFF3;
    set_taps(32'd2, 32'hFFFF_FFFF);
    xv[0] = 32'd3;
    xv[1] = 32'd5;
    xv[2] = 32'hFFFF_FFFC;
    do_run(3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (yv[i] !== exp[i]) begin
        n_bad++;
        $display("FAIL signed_y%0d got %h want %h", i, yv[i], exp[i]);
      end
    end
  endtask

  task automatic test_impulse;
    for (int i = 0; i < TN; i++) begin
      taps[i] = 32'(i + 1);
      xv[i]   = (i == 0) ? 32'd1 : 32'd0;
    end
    do_run(TN);
    n_cmp++;
    if (tmo !== 1'b0) begin
      n_bad++;
      $display("FAIL impulse_timeout got %b want 0", tmo);
    end
    for (int i = 0; i < TN; i++) begin
      n_cmp++;
      if (yv[i] !== 32'(i + 1)) begin
        n_bad++;
        $display("FAIL impulse_y%0d got %0d want %0d", i, yv[i], i + 1);
      end
    end
  endtask

  task automatic test_zero_len;
    int d0;
    int x0;
    int y0;
    bit seen;
    bit idle_in_done;
    d0 = done_cnt;
    x0 = xr_cnt;
    y0 = yv_cnt;
    seen = 1'b0;
    idle_in_done = 1'b1;
    @(negedge clk);
    bus.ap_start    = 1'b1;
    bus.data_length = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ap_start = 1'b0;
      if (bus.ap_done === 1'b1 && !seen) begin
        seen = 1'b1;
        idle_in_done = bus.ap_idle;
      end
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (seen !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_done_seen got %b want 1", seen);
    end
    n_cmp++;
    if (idle_in_done !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_idle_in_done got %b want 0", idle_in_done);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL zero_done_pulses got %0d want 1", done_cnt - d0);
    end
    n_cmp++;
    if (xr_cnt - x0 !== 0) begin
      n_bad++;
      $display("FAIL zero_x_ready got %0d want 0", xr_cnt - x0);
    end
    n_cmp++;
    if (yv_cnt - y0 !== 0) begin
      n_bad++;
      $display("FAIL zero_y_valid got %0d want 0", yv_cnt - y0);
    end
    n_cmp++;
    if (bus.ap_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_idle_after got %b want 1", bus.ap_idle);
    end
  endtask

  task automatic test_backpressure;
    int g;
    int bad;
    int d0;
    set_taps(32'd3, 32'd0);
    d0 = done_cnt;
    @(negedge clk);
    bus.ap_start    = 1'b1;
    bus.data_length = 32'd1;
    @(negedge clk);
    bus.ap_start = 1'b0;
    g = 0;
    while (bus.x_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    bus.x_valid = 1'b1;
    bus.x_data  = 32'd4;
    @(negedge clk);
    bus.x_valid = 1'b0;
    while (bus.y_valid !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (g >= 400) begin
      n_bad++;
      $display("FAIL bp_wait got %0d want <400", g);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.y_valid !== 1'b1) bad++;
      if (bus.y_data !== 32'd12) bad++;
      if (bus.x_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL bp_hold got %0d bad want 0 (y %h)",
               bad, bus.y_data);
    end
    bus.y_ready = 1'b1;
    @(negedge clk);
    bus.y_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL bp_done got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_overflow;
    set_taps(32'h7FFF_FFFF, 32'd0);
    xv[0] = 32'd2;
    do_run(1);
    n_cmp++;
    if (yv[0] !== 32'hFFFF_FFFE) begin
      n_bad++;
      $display("FAIL ovf_y got %h want fffffffe", yv[0]);
    end
    set_taps(32'd0, 32'd1);
    xv[0] = 32'd9;
    do_run(1);
    n_cmp++;
    if (yv[0] !== 32'd0) begin
      n_bad++;
      $display("FAIL ovf_history got %h want 0", yv[0]);
    end
  endtask

  task automatic test_reset_mid;
    int g;
    int d0;
    set_taps(32'd1, 32'd1);
    @(negedge clk);
    bus.ap_start    = 1'b1;
    bus.data_length = 32'd2;
    @(negedge clk);
    bus.ap_start = 1'b0;
    g = 0;
    while (bus.x_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    bus.x_valid = 1'b1;
    bus.x_data  = 32'd11;
    @(negedge clk);
    bus.x_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.ap_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_ap_idle got %b want 1", bus.ap_idle);
    end
    n_cmp++;
    if (bus.y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_y_valid got %b want 0", bus.y_valid);
    end
    n_cmp++;
    if (bus.tap_addr !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_tap_addr got %0d want 0", bus.tap_addr);
    end
    rst = 1'b0;
    d0 = done_cnt;
    xv[0] = 32'd13;
    do_run(1);
    n_cmp++;
    if (yv[0] !== 32'd13) begin
      n_bad++;
      $display("FAIL mid_fresh_y got %0d want 13", yv[0]);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL mid_fresh_done got %0d want 1", done_cnt - d0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.ap_start    = 1'b0;
    bus.data_length = 32'd0;
    bus.x_valid     = 1'b0;
    bus.x_data      = 32'd0;
    bus.y_ready     = 1'b0;
    for (int i = 0; i < TN; i++) taps[i] = 32'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_identity();
    test_signed();
    test_impulse();
    test_zero_len();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
